// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared types and helpers for the nibble-serial adder sequencer
package adder_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  function automatic int idx_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// rtl/adder_seq_ctrl_if.sv - request/result handshake bundle; op exists only with ADDER_SEQ_SUB_EN
interface adder_seq_ctrl_if
  import adder_seq_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef ADDER_SEQ_SUB_EN
  logic         op;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [W:0]   sum;
  logic         busy;

  modport master (
    output start_valid, a, b,
`ifdef ADDER_SEQ_SUB_EN
    output op,
`endif
    output res_ready,
    input  start_ready, res_valid, sum, busy
  );

  modport slave (
    input  start_valid, a, b,
`ifdef ADDER_SEQ_SUB_EN
    input  op,
`endif
    input  res_ready,
    output start_ready, res_valid, sum, busy
  );

endinterface

// File: rtl/adder_seq_ctrl_adder4_cin.sv
// rtl/adder_seq_ctrl_adder4_cin.sv - combinational 4-bit adder slice with carry-in and carry-out
module adder4_cin (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [4:0] s_o
);

  assign s_o = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - drives one shared 4-bit slice over NIBBLES nibbles per operation
// Subtraction support is built only when ADDER_SEQ_SUB_EN is defined.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  adder_seq_ctrl_if.slave  bus
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic [W:0]      sum_q, sum_d;
`ifdef ADDER_SEQ_SUB_EN
  logic            op_q, op_d;
`endif

  logic [3:0]      a_nib, b_nib, b_eff;
  logic [4:0]      slice_s;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[NIBBLE_W*i +: NIBBLE_W];
        b_nib = b_q[NIBBLE_W*i +: NIBBLE_W];
      end
    end
  end

`ifdef ADDER_SEQ_SUB_EN
  assign b_eff = b_nib ^ {4{op_q}};
`else
  assign b_eff = b_nib;
`endif

  adder4_cin u_slice (
    .a_i   (a_nib),
    .b_i   (b_eff),
    .cin_i (cy_q),
    .s_o   (slice_s)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
`ifdef ADDER_SEQ_SUB_EN
    op_d    = op_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = '0;
          sum_d   = '0;
`ifdef ADDER_SEQ_SUB_EN
          op_d    = bus.op;
          cy_d    = bus.op;
`else
          cy_d    = 1'b0;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IW'(i)) sum_d[NIBBLE_W*i +: NIBBLE_W] = slice_s[3:0];
        end
        cy_d  = slice_s[4];
        idx_d = idx_q + 1'b1;
        // the last slice's carry becomes the result's top bit
        if (idx_q == LAST_IDX) begin
          sum_d[W] = slice_s[4];
          idx_d    = '0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
`ifdef ADDER_SEQ_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
`ifdef ADDER_SEQ_SUB_EN
      op_q    <= op_d;
`endif
    end
  end

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.res_valid   = (state_q == ST_DONE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.sum         = sum_q;

endmodule
